// File: rtl/mux_pkg.sv
// Shared types and helpers for the pipelined N-to-1 word selector.
package mux_pkg;

    localparam int          BEAT_DATA_W          = 32;
    localparam logic [31:0] ILLEGAL_FILL_DEFAULT = 32'h0;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0] data;
        logic                   sel_err;
    } beat_t;

    // Minimum select width needed to address 'value' inputs.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/skid_reg.sv
// One-entry skid buffer: holds a beat that arrived while the main register was stalled.
module skid_reg #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             unload_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 word selector with valid/ready handshake, skid entry and
// illegal-select reporting (fill value, error flag, saturating counter).
module mux_nto1_pipe
    import mux_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               N_IN         = 6,
    parameter int               SEL_W        = 3,
    parameter logic [WIDTH-1:0] ILLEGAL_FILL = WIDTH'(ILLEGAL_FILL_DEFAULT),
    parameter int               ERR_CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_sel_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ERR_CNT_W-1:0]  err_count,
    input  logic                  err_clear
);

    if (SEL_W < clog2(N_IN) || N_IN < 2 || N_IN > 16) begin : g_param_check
        $error("mux_nto1_pipe: N_IN must be 2..16 and addressable by SEL_W");
    end

    logic [WIDTH-1:0]     in_words [N_IN];
    logic [WIDTH-1:0]     sel_word;
    logic                 sel_hit;
    logic [WIDTH:0]       in_beat;
    logic [WIDTH:0]       main_q, main_d;
    logic                 main_valid_q, main_valid_d;
    logic                 ready_q, ready_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic [WIDTH:0]       skid_data;
    logic                 skid_valid;
    logic                 accept, main_free, skid_load, skid_unload, err_inc;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_words
        assign in_words[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    // Unmatched selects fall through to the fill value, so out_data never sees X.
    always_comb begin
        sel_word = ILLEGAL_FILL;
        sel_hit  = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_word = in_words[k];
                sel_hit  = 1'b1;
            end
        end
    end

    assign in_beat     = {~sel_hit, sel_word};
    assign accept      = in_valid & ready_q;
    assign main_free   = ~main_valid_q | out_ready;
    assign skid_load   = accept & ~main_free;
    assign skid_unload = main_free & skid_valid;

    skid_reg #(
        .WIDTH(WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (skid_load),
        .unload_i(skid_unload),
        .data_i  (in_beat),
        .data_o  (skid_data),
        .valid_o (skid_valid)
    );

    // The skid entry is older than any incoming beat, so it refills main first.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        if (main_free) begin
            if (skid_valid) begin
                main_d       = skid_data;
                main_valid_d = 1'b1;
            end else if (accept) begin
                main_d       = in_beat;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end
    end

    assign ready_d     = ~(skid_load | (skid_valid & ~skid_unload));
    assign err_inc     = accept & ~sel_hit & ~(&err_count_q);
    assign err_count_d = err_clear ? '0 : err_count_q + ERR_CNT_W'(err_inc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            err_count_q  <= '0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            ready_q      <= ready_d;
            err_count_q  <= err_count_d;
        end
    end

    assign in_ready    = ready_q;
    assign out_data    = main_q[WIDTH-1:0];
    assign out_sel_err = main_q[WIDTH];
    assign out_valid   = main_valid_q;
    assign err_count   = err_count_q;

endmodule
